mem_data_dump: RTL and testbench
================================

Name: mem_data_dump

Overview:
- Read-side initiator for the processor data memory.
- Drives the memory's registered read port (addr_r in, data_out back one clock later).
- Streams a block of consecutive words out as bytes over a valid/ready interface.
- Used for debug readback of data memory contents to a serial or host link while the write port stays with the processor core.

Parameters:
- NADDRE, 8: number of memory words; address width is clog2(NADDRE).
- NBDATA, 32: memory word width in bits.
- NBYTES, ceil(NBDATA/8) (derived, localparam): bytes emitted per word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- base  in  clog2(NADDRE)  first word address; sampled with start.
- count  in  clog2(NADDRE)+1  number of words to dump; sampled with start.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the dump completes.
- addr_r  out  clog2(NADDRE)  read address to the memory (registered).
- data_out  in  NBDATA  memory read data, valid one clock after addr_r.
- tx_data  out  8  byte to the sink.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high at a clock edge.

Behaviour:
- Reset values: busy=0, done=0, tx_valid=0, tx_data=0, addr_r=0; FSM in IDLE; word counter and shift register cleared.
- A reset asserted mid-dump aborts the dump at that edge. No further bytes are sent and no done pulse is issued.
- FSM states: IDLE, RADDR, CAPT, SEND, DONE.
- IDLE:
  - On start=1, latch addr_r<=base and remaining<=count.
  - If count==0, go to DONE; otherwise go to RADDR.
  - start outside IDLE is ignored, including start during DONE.
- RADDR: addr_r is stable while the memory registers the word. Go to CAPT.
- CAPT:
  - Load the shift register with data_out, zero-extended to NBYTES*8 bits.
  - Byte index <= 0; tx_valid<=1 with tx_data = most-significant byte.
  - Go to SEND.
- SEND:
  - Bytes go out MSB first.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - On a handshake:
    - If not the last byte, shift and present the next byte in the following cycle. Back-to-back bytes are allowed; tx_valid stays high.
    - If the last byte, drop tx_valid and decrement remaining.
    - If remaining becomes 0, go to DONE.
    - Otherwise advance addr_r and go to RADDR.
- Address advance wraps from NADDRE-1 to 0, including when NADDRE is not a power of two.
- count > NADDRE is legal: words are re-read after the wrap.
- DONE: done=1 for exactly one cycle, busy drops at the same edge, return to IDLE.
- Latency:
  - start to first tx_valid is 3 cycles (IDLE→RADDR→CAPT→SEND).
  - Each subsequent word costs 2 idle cycles plus NBYTES handshakes.
- The block never drives the memory write port. Data written to a word during a dump is returned as current memory contents, with no coherence guarantee.

Decomposition:
- Shared package:
  - FSM state encoding constants.
  - Byte-width constant (8).
  - clog2-based width helper, shared with the memory blocks.
- One natural sub-module: word_serializer. It holds the shift register, the byte index and the valid/ready hold logic. It is loaded with a word and emits NBYTES bytes.

Test Plan:
- Base and count: memory preloaded with mem[i]=0x11223344+i; start with base=2, count=2, tx_ready=1 → bytes 11 22 33 46, 11 22 33 47; done pulses once; busy is high throughout.
- Backpressure: same setup with tx_ready toggling 1,0,0,1 → tx_data is held stable during stalls; byte order is unchanged; no byte is lost or duplicated.
- Wrap-around: NADDRE=8, base=7, count=3 → words read from 7, 0, 1 in that order.
- count=0 → no tx_valid; done pulses 2 cycles after start; start pulses during busy have no effect.
- Reset mid-dump: assert rst during the second byte → next cycle tx_valid=0, busy=0, no done; a new start then dumps correctly from base.
- Non-byte word: NBDATA=12, word 0xABC → bytes 0A BC.

Source files
------------

// File: rtl/mem_data_dump_pkg.sv
// Shared constants and helpers for the data-memory dump initiator.
// Other memory blocks use clog2w so that address widths agree.
package mem_data_dump_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_CAPT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Width for n distinct values. Never returns less than 1, so a
  // one-entry memory still gets a legal port.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_data_dump_word_serializer.sv
// Loads one memory word and emits it MSB-first as bytes over valid/ready.
// tx data comes straight from the top of the shift register, so it is registered.
module mem_data_dump_word_serializer
  import mem_data_dump_pkg::*;
#(
  parameter  int NBDATA = 32,
  localparam int NBYTES = (NBDATA + BYTE_W - 1) / BYTE_W,
  localparam int SW     = NBYTES * BYTE_W,
  localparam int IW     = clog2w(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NBDATA-1:0] word,
  input  logic              ready,
  output logic [7:0]        data,
  output logic              valid,
  output logic              last_fire
);

  logic [SW-1:0] sr;
  logic [SW-1:0] word_ext;
  logic [IW-1:0] idx;
  logic          fire;
  logic          last;

  always_comb begin
    word_ext             = '0;
    word_ext[NBDATA-1:0] = word;
  end

  assign fire      = valid & ready;
  assign last      = (idx == IW'(NBYTES - 1));
  assign last_fire = fire & last;
  assign data      = sr[SW-1 -: BYTE_W];

  // Without a handshake nothing here moves, which is what holds tx stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sr    <= word_ext;
      idx   <= '0;
      valid <= 1'b1;
    end else if (fire) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        sr  <= sr << BYTE_W;
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_data_dump.sv
// Read-side initiator: walks a block of data-memory words through the
// registered read port and streams them out as bytes.
module mem_data_dump
  import mem_data_dump_pkg::*;
#(
  parameter  int NADDRE = 8,
  parameter  int NBDATA = 32,
  localparam int AW     = clog2w(NADDRE),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base,
  input  logic [CW-1:0]     count,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     addr_r,
  input  logic [NBDATA-1:0] data_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(NADDRE - 1);

  state_t        state;
  logic [CW-1:0] remaining;
  logic [AW-1:0] next_addr;
  logic          load;
  logic          word_sent;

  // Explicit compare so non-power-of-two depths wrap correctly.
  assign next_addr = (addr_r == ADDR_LAST) ? '0 : addr_r + AW'(1);
  assign load      = (state == S_CAPT);

  mem_data_dump_word_serializer #(
    .NBDATA (NBDATA)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (data_out),
    .ready     (tx_ready),
    .data      (tx_data),
    .valid     (tx_valid),
    .last_fire (word_sent)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_r    <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_r    <= base;
            remaining <= count;
            busy      <= 1'b1;
            state     <= (count == '0) ? S_DONE : S_RADDR;
          end
        end
        S_RADDR: state <= S_CAPT;
        S_CAPT:  state <= S_SEND;
        S_SEND: begin
          if (word_sent) begin
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state <= S_DONE;
            end else begin
              addr_r <= next_addr;
              state  <= S_RADDR;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_dump.sv
// Two instances: 8 x 32-bit memory and 5 x 12-bit memory (non-byte word,
// non-power-of-two wrap), sharing control inputs and checked against a byte-list model.
module tb_mem_data_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  count;
  logic        tx_ready;

  logic        busy_a, done_a, txv_a;
  logic [2:0]  addr_a;
  logic [31:0] dout_a;
  logic [7:0]  txd_a;

  logic        busy_b, done_b, txv_b;
  logic [2:0]  addr_b;
  logic [11:0] dout_b;
  logic [7:0]  txd_b;

  logic [31:0] mem_a [8];
  logic [11:0] mem_b [8];

  logic [7:0]  obs_a [$];
  logic [7:0]  obs_b [$];
  int          ndone_a, ndone_b, nstall, nstall_bad;
  logic        pv_a, pv_b, pr;
  logic [7:0]  pd_a, pd_b;

  int          vectors, miscompares;

  mem_data_dump #(.NADDRE(8), .NBDATA(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy_a), .done(done_a), .addr_r(addr_a), .data_out(dout_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready)
  );

  mem_data_dump #(.NADDRE(5), .NBDATA(12)) dut_b (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy_b), .done(done_b), .addr_r(addr_b), .data_out(dout_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered read ports of the two memories.
  always @(posedge clk) begin
    dout_a <= mem_a[addr_a];
    dout_b <= mem_b[addr_b];
  end

  // Byte capture, done counting and hold-during-stall monitoring.
  initial begin
    ndone_a = 0; ndone_b = 0; nstall = 0; nstall_bad = 0;
    pv_a = 1'b0; pv_b = 1'b0; pr = 1'b0; pd_a = '0; pd_b = '0;
  end

  always @(posedge clk) begin
    if (txv_a && tx_ready) obs_a.push_back(txd_a);
    if (txv_b && tx_ready) obs_b.push_back(txd_b);
    if (done_a) ndone_a <= ndone_a + 1;
    if (done_b) ndone_b <= ndone_b + 1;
    if (!rst && pv_a && !pr) begin
      nstall <= nstall + 1;
      if (!(txv_a === 1'b1 && txd_a === pd_a)) nstall_bad <= nstall_bad + 1;
    end
    if (!rst && pv_b && !pr && !(txv_b === 1'b1 && txd_b === pd_b))
      nstall_bad <= nstall_bad + 1;
    pv_a <= txv_a && !rst;
    pv_b <= txv_b && !rst;
    pr   <= tx_ready;
    pd_a <= txd_a;
    pd_b <= txd_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One dump: build expected byte lists from memory contents, run it, compare.
  task automatic dump(input int b, input int c, input int rmode, input bit poke, input bit chk_b);
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int sa, sb, da, db, cyc, first_a, first_b, n;
    bit fin_a, fin_b;
    for (int k = 0; k < c; k++) begin
      logic [31:0] w;
      logic [11:0] v;
      w = mem_a[(b + k) % 8];
      for (int j = 3; j >= 0; j--) exp_a.push_back(8'(w >> (8 * j)));
      v = mem_b[(b + k) % 5];
      exp_b.push_back({4'h0, v[11:8]});
      exp_b.push_back(v[7:0]);
    end
    sa = obs_a.size(); sb = obs_b.size(); da = ndone_a; db = ndone_b;
    base = 3'(b); count = 4'(c); start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("busy_after_start_a b%0d c%0d", b, c), 32'(busy_a), 32'd1);
    cyc = 0; fin_a = 1'b0; fin_b = !chk_b; first_a = -1; first_b = -1;
    while (!(fin_a && fin_b) && cyc < 600) begin
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      start = poke && (cyc == 0 || cyc == 4);
      if (poke) begin
        base  = 3'($urandom_range(0, 4));
        count = 4'($urandom_range(1, 3));
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (!fin_a) begin
        if (txv_a && first_a < 0) first_a = cyc;
        if (done_a) begin
          fin_a = 1'b1;
          chk("busy_drop_a", 32'(busy_a), 32'd0);
          if (c == 0) chk("done_latency_a", 32'(cyc), 32'd1);
        end else chk($sformatf("busy_hold_a cyc%0d", cyc), 32'(busy_a), 32'd1);
      end
      if (!fin_b) begin
        if (txv_b && first_b < 0) first_b = cyc;
        if (done_b) begin
          fin_b = 1'b1;
          chk("busy_drop_b", 32'(busy_b), 32'd0);
          if (c == 0) chk("done_latency_b", 32'(cyc), 32'd1);
        end else chk($sformatf("busy_hold_b cyc%0d", cyc), 32'(busy_b), 32'd1);
      end
    end
    chk("dump_timeout", 32'(fin_a && fin_b), 32'd1);
    start = 1'b0; tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk($sformatf("nbytes_a b%0d c%0d", b, c), 32'(obs_a.size() - sa), 32'(exp_a.size()));
    n = (obs_a.size() - sa < exp_a.size()) ? obs_a.size() - sa : exp_a.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("byte_a b%0d c%0d i%0d", b, c, i), 32'(obs_a[sa + i]), 32'(exp_a[i]));
    chk("done_count_a", 32'(ndone_a - da), 32'd1);
    chk("idle_after_a", 32'(busy_a), 32'd0);
    if (c > 0) chk("first_valid_a", 32'(first_a), 32'd2);
    if (chk_b) begin
      chk($sformatf("nbytes_b b%0d c%0d", b, c), 32'(obs_b.size() - sb), 32'(exp_b.size()));
      n = (obs_b.size() - sb < exp_b.size()) ? obs_b.size() - sb : exp_b.size();
      for (int i = 0; i < n; i++)
        chk($sformatf("byte_b b%0d c%0d i%0d", b, c, i), 32'(obs_b[sb + i]), 32'(exp_b[i]));
      chk("done_count_b", 32'(ndone_b - db), 32'd1);
      if (c > 0) chk("first_valid_b", 32'(first_b), 32'd2);
    end
  endtask

  initial begin
    int sa, da, cyc;
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; base = '0; count = '0; tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 32'h1122_3344 + 32'(i);
      mem_b[i] = 12'($urandom);
    end
    mem_b[0] = 12'hABC;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_txv", 32'(txv_a), 32'd0);
    chk("reset_txd", 32'(txd_a), 32'd0);
    chk("reset_addr", 32'(addr_a), 32'd0);
    chk("reset_txv_b", 32'(txv_b), 32'd0);

    dump(2, 2, 0, 1'b0, 1'b1);   // 11 22 33 46, 11 22 33 47
    dump(2, 2, 1, 1'b0, 1'b1);   // ready 1,0,0,1
    dump(7, 3, 0, 1'b0, 1'b0);   // wrap 7,0,1 on the 8-word memory
    dump(3, 4, 2, 1'b0, 1'b1);   // wrap 3,4,0,1 on the 5-word memory
    dump(0, 0, 0, 1'b1, 1'b1);   // empty dump, start during DONE ignored
    dump(0, 2, 0, 1'b1, 1'b1);   // start during busy ignored
    dump(0, 1, 0, 1'b0, 1'b1);   // 12-bit word ABC -> 0A BC

    // Reset while the second byte is on offer.
    sa = obs_a.size(); da = ndone_a;
    base = 3'd1; count = 4'd3; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (obs_a.size() < sa + 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_first_byte", 32'(obs_a.size() - sa), 32'd1);
    chk("rst_second_valid", 32'(txv_a), 32'd1);
    rst = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_abort_txv", 32'(txv_a), 32'd0);
    chk("rst_abort_busy", 32'(busy_a), 32'd0);
    chk("rst_abort_done", 32'(done_a), 32'd0);
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", 32'(ndone_a - da), 32'd0);
    chk("rst_no_more_bytes", 32'(obs_a.size() - sa), 32'd1);
    dump(1, 3, 0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] = $urandom;
        mem_b[i] = 12'($urandom);
      end
      dump($urandom_range(0, 4), $urandom_range(0, 10), $urandom_range(0, 2), 1'b0, 1'b1);
    end

    chk("stall_hold_violations", 32'(nstall_bad), 32'd0);
    chk("stalls_exercised", 32'(nstall > 0), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
